stack_lifo_core: RTL and testbench

- LIFO storage engine that sits directly below the tt_um_yannickreiss_stack top level.
- The top level decodes ui_in/uio_in into push/pop commands and drives this block. It maps data_out and the flags onto uo_out/uio_out.
- Storage is a register-file stack with a registered read port, depth tracking, and sticky overflow/underflow error flags.

---
 rtl/stack_lifo_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_stack_lifo_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_lifo_core.sv
// -----------------------------------------------------------------------------
// stack_lifo_core
//
// LIFO storage engine below the tt_um_yannickreiss_stack top level. It holds a
// register-file stack with a registered read port, tracks the fill level and
// keeps sticky overflow/underflow error flags.
//
// Optional feature (compile-time macro):
//   STACK_ARITH_EN - when defined, op_add pops the top two entries and pushes
//                    their wrapped sum. When undefined, op_add is ignored and
//                    no adder exists in the design.
//
// Parameters:
//   WIDTH  data word width in bits
//   DEPTH  number of stack entries (>= 2)
//   CW     width of count, derived as $clog2(DEPTH+1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   design enable; 0 freezes all state and ignores commands
//   push       in   push push_data this cycle
//   push_data  in   word to push
//   pop        in   pop the top entry this cycle
//   op_add     in   add command (only with STACK_ARITH_EN)
//   clr_err    in   clear the sticky error flags
//   data_out   out  last popped / computed word (registered)
//   out_valid  out  one-cycle pulse: data_out was updated
//   top        out  current top-of-stack word, 0 when empty
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky: a push was dropped
//   underflow  out  sticky: a pop or add was rejected
// -----------------------------------------------------------------------------
module stack_lifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             op_add,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // Storage index width; entries are addressed 0..DEPTH-1.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    count_q,     count_d;
  logic [WIDTH-1:0] data_out_q,  data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;

  // Single storage write port, steered by the command decode.
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [WIDTH-1:0] mem_wdata_s;

  // ---------------------------------------------------------------------------
  // Derived pointers and status
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    cnt_p1_s;
  logic [CW-1:0]    cnt_m1_s;
  logic [AW-1:0]    push_idx_s;
  logic [AW-1:0]    top_idx_s;
  logic [WIDTH-1:0] top_word_s;
  logic             empty_s;
  logic             full_s;

  // The write pointer is count itself: the next free slot is mem[count].
  assign cnt_p1_s   = count_q + ONE_C;
  assign cnt_m1_s   = count_q - ONE_C;
  assign push_idx_s = count_q[AW-1:0];
  // When empty, cnt_m1 wraps; the index is harmless because top is masked.
  assign top_idx_s  = cnt_m1_s[AW-1:0];

  assign empty_s    = (count_q == ZERO_C);
  assign full_s     = (count_q == DEPTH_C);
  assign top_word_s = mem_q[top_idx_s];

  // ---------------------------------------------------------------------------
  // Optional add datapath
  // ---------------------------------------------------------------------------
  logic             add_cmd_s;
  logic             add_ok_s;
  logic [AW-1:0]    add_idx_s;
  logic [WIDTH-1:0] sum_s;

`ifdef STACK_ARITH_EN
  localparam logic [CW-1:0] TWO_C = CW'(2);

  logic [CW-1:0]    cnt_m2_s;
  logic [WIDTH-1:0] next_word_s;

  assign cnt_m2_s    = count_q - TWO_C;
  assign add_idx_s   = cnt_m2_s[AW-1:0];
  assign next_word_s = mem_q[add_idx_s];
  assign add_cmd_s   = op_add;
  assign add_ok_s    = (count_q >= TWO_C);
  // Natural WIDTH-bit wrap gives the mod 2^WIDTH result.
  assign sum_s       = top_word_s + next_word_s;
`else
  // op_add is a dead input in this build; the tie-offs let the add branch
  // below fold away entirely.
  logic unused_op_add_s;

  assign unused_op_add_s = op_add;
  assign add_cmd_s       = 1'b0;
  assign add_ok_s        = 1'b0;
  assign add_idx_s       = {AW{1'b0}};
  assign sum_s           = {WIDTH{1'b0}};
`endif

  // ---------------------------------------------------------------------------
  // Command decode: next-state for counters, outputs, flags and write port
  // ---------------------------------------------------------------------------
  // Compute next state from the sampled command set.
  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = push_idx_s;
    mem_wdata_s = push_data;

    if (ena) begin
      // Clear first so that an error raised on the same edge overrides it.
      if (clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
      end

      if (add_cmd_s) begin
        // add overrides push/pop: pop a and b, push a+b into b's slot.
        if (add_ok_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = add_idx_s;
          mem_wdata_s = sum_s;
          count_d     = cnt_m1_s;
          data_out_d  = sum_s;
          out_valid_d = 1'b1;
        end else begin
          underflow_d = 1'b1;
        end
      end else begin
        case ({push, pop})
          2'b10: begin
            if (!full_s) begin
              mem_we_s    = 1'b1;
              mem_waddr_s = push_idx_s;
              count_d     = cnt_p1_s;
            end else begin
              overflow_d  = 1'b1;
            end
          end
          2'b01: begin
            if (!empty_s) begin
              data_out_d  = top_word_s;
              count_d     = cnt_m1_s;
              out_valid_d = 1'b1;
            end else begin
              underflow_d = 1'b1;
            end
          end
          2'b11: begin
            if (!empty_s) begin
              // Swap the top: return old top, overwrite in place. Depth is
              // unchanged, so this is legal even when full.
              mem_we_s    = 1'b1;
              mem_waddr_s = top_idx_s;
              data_out_d  = top_word_s;
              out_valid_d = 1'b1;
            end else begin
              // Nothing to pop: degrade to a plain push and flag the pop.
              // An empty stack can never be full since DEPTH >= 2.
              mem_we_s    = 1'b1;
              mem_waddr_s = push_idx_s;
              count_d     = cnt_p1_s;
              underflow_d = 1'b1;
            end
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
    end else begin
      // Disabled: hold everything; out_valid drops via its default.
      count_d = count_q;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= {CW{1'b0}};
      data_out_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array: contents need no reset because count masks them.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign top       = empty_s ? {WIDTH{1'b0}} : top_word_s;

endmodule

// File: tb/tb_stack_lifo_core.sv
// -----------------------------------------------------------------------------
// tb_stack_lifo_core
//
// Directed bench for stack_lifo_core. Each command that should produce an
// out_valid pulse pushes its hand-computed data word into a scoreboard queue;
// a monitor process pops and compares on every out_valid. State outputs
// (count/top/flags) are checked directly against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_stack_lifo_core;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             op_add;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q [$];

  stack_lifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .op_add    (op_add),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .out_valid (out_valid),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one command for one clock edge; optionally queue the expected word.
  task automatic cmd(input logic p, input logic [WIDTH-1:0] d, input logic po,
                     input logic a, input logic c,
                     input logic exp_v, input logic [WIDTH-1:0] exp_d);
    push      = p;
    push_data = d;
    pop       = po;
    op_add    = a;
    clr_err   = c;
    if (exp_v) exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    op_add  = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [CW-1:0] c,
                             input logic [WIDTH-1:0] t, input logic ov, input logic un);
    check({tag, " count"},     count,     c);
    check({tag, " top"},       top,       t);
    check({tag, " overflow"},  overflow,  ov);
    check({tag, " underflow"}, underflow, un);
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("out_valid with nothing pending", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("popped data", data_out, e);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    push      = 1'b0;
    push_data = '0;
    pop       = 1'b0;
    op_add    = 1'b0;
    clr_err   = 1'b0;

    // Power-on reset state.
    #1;
    check("reset count",     count,     0);
    check("reset empty",     empty,     1);
    check("reset top",       top,       0);
    check("reset data_out",  data_out,  0);
    check("reset out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic LIFO order.
    cmd(1, 8'h11, 0, 0, 0, 0, 8'h00);
    cmd(1, 8'h22, 0, 0, 0, 0, 8'h00);
    cmd(1, 8'h33, 0, 0, 0, 0, 8'h00);
    check_state("after 3 pushes", 5'd3, 8'h33, 0, 0);
    check("push leaves out_valid low", out_valid, 0);
    cmd(0, 8'h00, 1, 0, 0, 1, 8'h33);
    check("out_valid one cycle after pop", out_valid, 1);
    cmd(0, 8'h00, 1, 0, 0, 1, 8'h22);
    cmd(0, 8'h00, 1, 0, 0, 1, 8'h11);
    cmd(0, 8'h00, 0, 0, 0, 0, 8'h00);
    check("pulse ends", out_valid, 0);
    check("empty after drain", empty, 1);
    check_state("after drain", 5'd0, 8'h00, 0, 0);

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < DEPTH; i++) cmd(1, 8'(i), 0, 0, 0, 0, 8'h00);
    check("full after fill", full, 1);
    check_state("after fill", 5'd16, 8'h0F, 0, 0);
    cmd(1, 8'hAA, 0, 0, 0, 0, 8'h00);
    check_state("push on full", 5'd16, 8'h0F, 1, 0);
    cmd(0, 8'h00, 0, 0, 1, 0, 8'h00);
    check_state("clr_err", 5'd16, 8'h0F, 0, 0);

    // Swap while full: no overflow, depth unchanged.
    cmd(1, 8'h5A, 1, 0, 0, 1, 8'h0F);
    check("full after swap", full, 1);
    check_state("swap on full", 5'd16, 8'h5A, 0, 0);

    // Drain everything: 5A then 0E..00.
    cmd(0, 8'h00, 1, 0, 0, 1, 8'h5A);
    for (int i = 14; i >= 0; i--) cmd(0, 8'h00, 1, 0, 0, 1, 8'(i));
    check_state("drained", 5'd0, 8'h00, 0, 0);

    // Pop on empty.
    cmd(0, 8'h00, 1, 0, 0, 0, 8'h00);
    check_state("pop on empty", 5'd0, 8'h00, 0, 1);
    check("pop on empty out_valid", out_valid, 0);
    // Error raised on the same edge as clr_err: set wins.
    cmd(0, 8'h00, 1, 0, 1, 0, 8'h00);
    check("set beats clear", underflow, 1);
    cmd(0, 8'h00, 0, 0, 1, 0, 8'h00);
    check("clear underflow", underflow, 0);

    // Push+pop on empty behaves as push plus underflow.
    cmd(1, 8'h77, 1, 0, 0, 0, 8'h00);
    check_state("push+pop on empty", 5'd1, 8'h77, 0, 1);
    check("push+pop on empty out_valid", out_valid, 0);
    cmd(0, 8'h00, 0, 0, 1, 0, 8'h00);

    // Pop then disable: out_valid must drop and state must freeze.
    cmd(0, 8'h00, 1, 0, 0, 1, 8'h77);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd(1, 8'hC0 + 8'(i), 0, 0, 0, 0, 8'h00);
      check("ena=0 out_valid", out_valid, 0);
    end
    check_state("ena=0 pushes", 5'd0, 8'h00, 0, 0);
    check("ena=0 data_out held", data_out, 8'h77);
    ena = 1'b1;

    // Asynchronous reset mid-stream.
    cmd(1, 8'hA1, 0, 0, 0, 0, 8'h00);
    cmd(1, 8'hA2, 0, 0, 0, 0, 8'h00);
    cmd(1, 8'hA3, 0, 0, 0, 0, 8'h00);
    check("count before reset", count, 3);
    rst_n = 1'b0;
    #2;
    check("async reset count",    count,    0);
    check("async reset empty",    empty,    1);
    check("async reset top",      top,      0);
    check("async reset data_out", data_out, 0);
    check("async reset flags",    {overflow, underflow}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Add command.
    cmd(1, 8'hF0, 0, 0, 0, 0, 8'h00);
    cmd(1, 8'h20, 0, 0, 0, 0, 8'h00);
`ifdef STACK_ARITH_EN
    cmd(0, 8'h00, 0, 1, 0, 1, 8'h10);
    check("add out_valid", out_valid, 1);
    check_state("after add", 5'd1, 8'h10, 0, 0);
    cmd(0, 8'h00, 0, 1, 0, 0, 8'h00);
    check_state("add with one entry", 5'd1, 8'h10, 0, 1);
`else
    cmd(0, 8'h00, 0, 1, 0, 0, 8'h00);
    check("op_add ignored out_valid", out_valid, 0);
    check_state("op_add ignored", 5'd2, 8'h20, 0, 0);
    cmd(0, 8'h00, 0, 1, 0, 0, 8'h00);
    check_state("op_add ignored again", 5'd2, 8'h20, 0, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
